// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_fetch_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned TIMER_W = 8;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [1:0]      ALIGN_MASK       = 2'b00;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    // True when the address is a legal word-aligned fetch target.
    function automatic logic is_aligned(input logic [XLEN-1:0] addr);
        return addr[1:0] == ALIGN_MASK;
    endfunction

endpackage

// File: rtl/ifu_timeout_ctr.sv
// Counts cycles spent waiting for imem_ack; expire_c flags the last allowed cycle.
module ifu_timeout_ctr
    import ifu_fetch_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire_c
);

    logic [TIMER_W-1:0] count;

    // Wait counter: clear has priority over counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + TIMER_W'(1);
        end
    end

    assign expire_c = en && (count == TIMER_W'(TIMEOUT - 1));

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: holds the PC, runs the imem handshake, hands words to decode.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned     TIMEOUT  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] npc_in,
    input  logic            instr_ready,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] instr_out,
    output logic            instr_valid,
    output logic            fault,
    output logic [XLEN-1:0] fault_pc
);

    state_t          state, state_n;
    logic [XLEN-1:0] pc_n, instr_n, fault_pc_n;
    logic            valid_n, req_n, fault_n;
    logic            expire_c;

    // Timer runs only in REQ; any other state or an ack restarts it from zero.
    ifu_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (imem_ack || (state != ST_REQ)),
        .en       (state == ST_REQ),
        .expire_c (expire_c)
    );

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RESET;
            pc_out      <= RESET_PC;
            instr_out   <= '0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            fault       <= 1'b0;
            fault_pc    <= '0;
        end else begin
            state       <= state_n;
            pc_out      <= pc_n;
            instr_out   <= instr_n;
            instr_valid <= valid_n;
            imem_req    <= req_n;
            fault       <= fault_n;
            fault_pc    <= fault_pc_n;
        end
    end

    // Next-state and next-output logic; ack beats a simultaneous timeout.
    always_comb begin
        state_n    = state;
        pc_n       = pc_out;
        instr_n    = instr_out;
        valid_n    = instr_valid;
        req_n      = 1'b0;
        fault_n    = fault;
        fault_pc_n = fault_pc;

        case (state)
            ST_RESET: begin
                state_n = ST_REQ;
                req_n   = 1'b1;
            end
            ST_REQ: begin
                if (imem_ack) begin
                    instr_n = imem_rdata;
                    valid_n = 1'b1;
                    state_n = ST_HOLD;
                end else if (expire_c) begin
                    fault_n    = 1'b1;
                    fault_pc_n = pc_out;
                    state_n    = ST_HALT;
                end else begin
                    req_n = 1'b1;
                end
            end
            ST_HOLD: begin
                if (instr_ready) begin
                    valid_n = 1'b0;
                    if (!is_aligned(npc_in)) begin
                        fault_n    = 1'b1;
                        fault_pc_n = npc_in;
                        state_n    = ST_HALT;
                    end else begin
                        pc_n    = npc_in;
                        req_n   = 1'b1;
                        state_n = ST_REQ;
                    end
                end
            end
            ST_HALT: begin
                state_n = ST_HALT;
            end
            default: begin
                state_n = ST_HALT;
            end
        endcase
    end

    assign imem_addr = pc_out;

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: random memory/decode traffic against a transaction model.
module tb_ifu_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam int unsigned TMO    = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] npc_in = '0;
    logic        instr_ready = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req;
    logic [31:0] imem_addr, pc_out, instr_out, fault_pc;
    logic        instr_valid, fault;

    int total = 0;
    int bad   = 0;

    logic [63:0] exp_instr[$];   // {pc, instr} expected at each decode accept
    logic [31:0] exp_addr[$];    // address expected at each new fetch request
    logic [31:0] exp_fault[$];   // fault_pc expected when fault rises

    logic [31:0] model_pc;

    ifu_fetch #(
        .RESET_PC (RST_PC),
        .TIMEOUT  (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .npc_in      (npc_in),
        .instr_ready (instr_ready),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .pc_out      (pc_out),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .fault       (fault),
        .fault_pc    (fault_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reset the DUT; optionally hold a stale ack across reset and the first cycle after it.
    task automatic do_reset(input bit stale);
        @(negedge clk);
        rst_n       = 1'b0;
        instr_ready = 1'b0;
        imem_ack    = stale;
        imem_rdata  = 32'hDEAD_BEEF;
        exp_instr.delete();
        exp_addr.delete();
        exp_fault.delete();
        model_pc = RST_PC;
        #1;
        chk("rst_pc", pc_out, RST_PC);
        chk("rst_addr", imem_addr, RST_PC);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr_out, 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_fault_pc", fault_pc, 32'd0);
        repeat (2) @(negedge clk);
        exp_addr.push_back(RST_PC);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        chk("post_rst_req", 32'(imem_req), 32'd1);
        chk("post_rst_valid", 32'(instr_valid), 32'd0);
        chk("post_rst_pc", pc_out, RST_PC);
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(negedge clk);
            instr_ready = 1'b0;
            imem_ack    = 1'b0;
        end
    endtask

    // One fetch: ack after dly wait cycles, stall decode, then accept with npc.
    task automatic fetch(input int unsigned dly, input logic [31:0] data,
                         input int unsigned stall, input logic [31:0] npc);
        int n = 0;
        @(negedge clk);
        instr_ready = 1'b0;
        imem_ack    = 1'b0;
        while (!imem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!imem_req) begin
            chk("req_wait_expired", 32'(imem_req), 32'd1);
            return;
        end
        repeat (dly) @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = data;
        exp_instr.push_back({model_pc, data});
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        repeat (stall) @(negedge clk);
        instr_ready = 1'b1;
        npc_in      = npc;
        if (npc[1:0] != 2'b00) begin
            exp_fault.push_back(npc);
        end else begin
            model_pc = npc;
            exp_addr.push_back(npc);
        end
    endtask

    // Withhold ack: fault must appear only after TMO request cycles.
    task automatic timeout_case();
        exp_fault.push_back(model_pc);
        for (int i = 1; i <= int'(TMO); i++) begin
            @(negedge clk);
            instr_ready = 1'b0;
            imem_ack    = 1'b0;
            if (i == int'(TMO)) begin
                chk("tmo_no_early_fault", 32'(fault), 32'd0);
                chk("tmo_req_last", 32'(imem_req), 32'd1);
            end
        end
        @(negedge clk);
        chk("tmo_fault", 32'(fault), 32'd1);
        chk("tmo_req_off", 32'(imem_req), 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        chk("tmo_stale_valid", 32'(instr_valid), 32'd0);
        chk("tmo_stale_instr", instr_out, 32'd0);
        chk("tmo_fault_pc_hold", fault_pc, RST_PC);
    endtask

    // Monitor: pops the scoreboard and checks handshake timing rules.
    logic        p_req, p_ack, p_valid, p_ready, p_fault, p_npc_ok;
    logic [31:0] p_pc, p_instr, p_fault_pc;

    initial begin
        p_req = 0; p_ack = 0; p_valid = 0; p_ready = 0; p_fault = 0; p_npc_ok = 0;
        p_pc = '0; p_instr = '0; p_fault_pc = '0;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) begin
                p_req = 0; p_ack = 0; p_valid = 0; p_ready = 0; p_fault = 0; p_npc_ok = 0;
            end else begin
                if (imem_addr !== pc_out) chk("addr_eq_pc", imem_addr, pc_out);
                if (imem_req && instr_valid) chk("req_and_valid", 32'd1, 32'd0);
                if (imem_req && !p_req) begin
                    if (exp_addr.size() == 0) chk("addr_unexpected", imem_addr, 32'hFFFF_FFFF);
                    else chk("fetch_addr", imem_addr, exp_addr.pop_front());
                end
                if (p_req && p_ack) begin
                    chk("ack_to_valid", 32'(instr_valid), 32'd1);
                    chk("req_drop_after_ack", 32'(imem_req), 32'd0);
                end
                if (p_valid && !p_ready) begin
                    chk("stall_pc", pc_out, p_pc);
                    chk("stall_instr", instr_out, p_instr);
                    chk("stall_req", 32'(imem_req), 32'd0);
                end
                if (p_valid && p_ready && p_npc_ok) begin
                    chk("accept_to_req", 32'(imem_req), 32'd1);
                    chk("accept_valid_off", 32'(instr_valid), 32'd0);
                end
                if (instr_valid && instr_ready) begin
                    if (exp_instr.size() == 0) chk("instr_unexpected", instr_out, 32'hFFFF_FFFF);
                    else begin
                        logic [63:0] e;
                        e = exp_instr.pop_front();
                        chk("instr_pc", pc_out, e[63:32]);
                        chk("instr_word", instr_out, e[31:0]);
                    end
                end
                if (fault && !p_fault) begin
                    if (exp_fault.size() == 0) chk("fault_unexpected", fault_pc, 32'hFFFF_FFFF);
                    else chk("fault_pc", fault_pc, exp_fault.pop_front());
                    chk("fault_valid_off", 32'(instr_valid), 32'd0);
                    chk("fault_req_off", 32'(imem_req), 32'd0);
                end
                if (p_fault) begin
                    if (!fault) chk("fault_sticky", 32'(fault), 32'd1);
                    if (fault_pc !== p_fault_pc) chk("fault_pc_sticky", fault_pc, p_fault_pc);
                end
                p_req      = imem_req;
                p_ack      = imem_ack;
                p_valid    = instr_valid;
                p_ready    = instr_ready;
                p_npc_ok   = (npc_in[1:0] == 2'b00);
                p_fault    = fault;
                p_pc       = pc_out;
                p_instr    = instr_out;
                p_fault_pc = fault_pc;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] npc;
        model_pc = RST_PC;

        do_reset(1'b0);
        fetch(0, 32'h2408_0005, 0, 32'h0000_3004);
        fetch(2, 32'hA5A5_0001, 5, 32'h0000_3040);
        fetch(0, 32'h0BAD_0002, 0, 32'h0000_3042);
        idle(4);
        chk("misalign_req_off", 32'(imem_req), 32'd0);
        chk("misalign_pc_kept", pc_out, 32'h0000_3040);

        do_reset(1'b0);
        timeout_case();

        do_reset(1'b0);
        fetch(TMO - 1, 32'hCAFE_0016, 0, 32'h0000_3010);
        idle(1);
        chk("boundary_no_fault", 32'(fault), 32'd0);
        chk("mid_req_pc", pc_out, 32'h0000_3010);
        idle(2);
        do_reset(1'b1);

        fetch(0, 32'h1111_0001, 0, 32'hFFFF_FFFC);
        fetch(1, 32'h2222_0002, 1, 32'h0000_0000);
        fetch(0, 32'h3333_0003, 0, 32'h0000_0004);
        idle(1);
        chk("wrap_no_fault", 32'(fault), 32'd0);
        chk("wrap_pc", pc_out, 32'h0000_0004);

        for (int it = 0; it < 60; it++) begin
            r = $urandom;
            if ($urandom_range(0, 9) == 0) npc = {r[31:2], 2'($urandom_range(1, 3))};
            else npc = {r[31:2], 2'b00};
            fetch($urandom_range(0, TMO - 1), $urandom, $urandom_range(0, 3), npc);
            if (npc[1:0] != 2'b00) begin
                idle(3);
                do_reset(1'b0);
            end
        end

        idle(6);
        chk("drain_instr", 32'(exp_instr.size()), 32'd0);
        chk("drain_addr", 32'(exp_addr.size()), 32'd0);
        chk("drain_fault", 32'(exp_fault.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
